trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Parametrised multicycle trap/exception sequencer for the RV64 multicycle core; successor to the fixed two-vector (254/255) EPC scheme.
- Accepts NCAUSE prioritised trap requests, captures the faulting PC into EPC plus a cause code, fetches the handler address from a vector table in data memory, and redirects the PC.
- Supports return-from-trap (Mret) by redirecting the PC to EPC.
- Sits between the control unit, the PC register/mux and the 64-bit data memory read port; holds the control unit via Stall while sequencing.

Parameters:
XLEN, 64, datapath/address width
NCAUSE, 4, number of trap request lines
CW, 2, cause code width (must be >= clog2(NCAUSE))
VEC_BASE, 254, address of vector entry for cause 0
VEC_STRIDE, 1, address increment per cause index
MEM_LAT, 1, cycles from MemRdEn cycle to MemRdData valid (>=1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
TrapReq  in  NCAUSE  level trap requests; bit 0 highest priority
Mret  in  1  one-cycle return-from-trap pulse
PC  in  XLEN  address of the current instruction
MemRdData  in  XLEN  vector table read data
MemRdEn  out  1  vector table read strobe
MemRdAddr  out  XLEN  vector table read address
NewPC  out  XLEN  redirect target
PCWrite  out  1  one-cycle PC load strobe
EPC  out  XLEN  saved exception PC
Cause  out  CW  index of the accepted trap
InTrap  out  1  handler active (between trap entry and Mret)
Stall  out  1  control unit must hold while high
TrapLost  out  1  sticky: a request was dropped

Behaviour:
- Reset (sync): state IDLE; all outputs 0; wait counter 0. Reset overrides any state, including mid-sequence; no PCWrite is issued in the reset cycle.
- States: IDLE -> READ -> WAIT -> REDIRECT -> IDLE.
- IDLE, TrapReq != 0, InTrap = 0:
  - Select the lowest set bit index k.
  - At the edge: EPC <= PC, Cause <= k, InTrap <= 1, go to READ.
- READ (1 cycle):
  - MemRdEn = 1.
  - MemRdAddr = VEC_BASE + k*VEC_STRIDE, computed modulo 2^XLEN (wraps).
  - Go to WAIT.
- WAIT (exactly MEM_LAT cycles):
  - Counter runs 1..MEM_LAT.
  - On the last WAIT cycle, register MemRdData into NewPC and go to REDIRECT.
- REDIRECT (1 cycle): PCWrite = 1, NewPC stable; go to IDLE.
- Trap latency: TrapReq sampled at end of cycle 0 -> PCWrite high in cycle 2+MEM_LAT.
- Stall = 1 in READ, WAIT and REDIRECT; Stall = 0 in IDLE.
- MemRdEn and MemRdAddr are 0 outside READ.
- IDLE, Mret = 1, InTrap = 1, TrapReq = 0:
  - Next cycle NewPC = EPC, PCWrite = 1 for one cycle, InTrap <= 0.
  - Stall stays 0 (no state change).
- Mret with InTrap = 0: ignored.
- Mret in any non-IDLE state: ignored.
- Simultaneous TrapReq != 0 and Mret in IDLE with InTrap = 1: trap is not nestable; request dropped, TrapLost <= 1, Mret is serviced.
- Simultaneous TrapReq != 0 and Mret in IDLE with InTrap = 0: trap wins, Mret dropped (TrapLost unaffected).
- TrapReq != 0 while in READ, WAIT or REDIRECT, or while InTrap = 1: request dropped, TrapLost <= 1. TrapLost is cleared only by Reset.
- EPC and Cause hold between traps; they are not cleared by Mret.
- PCWrite is never high on two consecutive cycles.
- Multiple bits set: only the lowest index is serviced; the other bits are not queued.

Test Plan:
- Reset, then TrapReq=4'b0100, PC=64'h40, VEC_BASE=254, MEM_LAT=1, memory returns 64'h1000 at address 256:
  - MemRdEn=1 with MemRdAddr=256 in cycle 1.
  - Cycle 3: PCWrite=1, NewPC=64'h1000.
  - EPC=64'h40, Cause=2, InTrap=1; Stall high in cycles 1-3.
- After the above, pulse Mret -> next cycle PCWrite=1, NewPC=64'h40, InTrap=0, Stall stays 0.
- TrapReq=4'b0110 -> Cause=1, MemRdAddr=255; bit 2 not serviced, TrapLost stays 0.
- MEM_LAT=3 build, TrapReq=4'b0001, VEC_BASE=64'hFFFF_FFFF_FFFF_FFFF -> MemRdAddr=2^64-1 in cycle 1; PCWrite in cycle 5; a second TrapReq raised during WAIT -> TrapLost=1.
- With InTrap=1: TrapReq=4'b1000 together with Mret -> EPC return performed, TrapLost=1, no vector read.
- Reset asserted during WAIT:
  - Next cycle all outputs 0 and state IDLE; no PCWrite.
  - A fresh TrapReq afterwards runs the full sequence normally.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: multicycle trap/exception sequencer.
// Accepts prioritised trap requests, saves PC/cause, fetches the handler
// address from a vector table in data memory and redirects the PC.
// Also services return-from-trap (Mret) by redirecting to EPC.
module trap_ctrl #(
  parameter int unsigned      XLEN       = 64,
  parameter int unsigned      NCAUSE     = 4,
  parameter int unsigned      CW         = 2,
  parameter logic [XLEN-1:0]  VEC_BASE   = XLEN'(254),
  parameter logic [XLEN-1:0]  VEC_STRIDE = XLEN'(1),
  parameter int unsigned      MEM_LAT    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NCAUSE-1:0] TrapReq,
  input  logic              Mret,
  input  logic [XLEN-1:0]   PC,
  input  logic [XLEN-1:0]   MemRdData,
  output logic              MemRdEn,
  output logic [XLEN-1:0]   MemRdAddr,
  output logic [XLEN-1:0]   NewPC,
  output logic              PCWrite,
  output logic [XLEN-1:0]   EPC,
  output logic [CW-1:0]     Cause,
  output logic              InTrap,
  output logic              Stall,
  output logic              TrapLost
);

  localparam int unsigned CNTW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_REDIRECT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_wcnt;
  logic [XLEN-1:0] r_epc;
  logic [CW-1:0]   r_cause;
  logic            r_intrap;
  logic [XLEN-1:0] r_newpc;
  logic            r_retpw;
  logic            r_lost;

  logic            w_req_any;
  logic            w_found;
  logic [CW-1:0]   w_k;
  logic            w_take;
  logic            w_ret;
  logic            w_wait_last;
  logic [XLEN-1:0] w_vec_addr;

  assign w_req_any   = |TrapReq;
  assign w_take      = (r_state == S_IDLE) && w_req_any && !r_intrap;
  assign w_ret       = (r_state == S_IDLE) && Mret && r_intrap;
  assign w_wait_last = (r_wcnt == CNTW'(MEM_LAT));
  assign w_vec_addr  = VEC_BASE + XLEN'(r_cause) * VEC_STRIDE;

  // Priority encoder: lowest set request bit wins
  always_comb begin
    w_k     = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NCAUSE; i++) begin
      if (TrapReq[i] && !w_found) begin
        w_k     = CW'(i);
        w_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_take) w_state_nxt = S_READ;
      S_READ:     w_state_nxt = S_WAIT;
      S_WAIT:     if (w_wait_last) w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Memory wait counter, runs 1..MEM_LAT while in WAIT
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wcnt <= '0;
    end else begin
      case (r_state)
        S_READ:  r_wcnt <= CNTW'(1);
        S_WAIT:  r_wcnt <= w_wait_last ? '0 : r_wcnt + CNTW'(1);
        default: r_wcnt <= '0;
      endcase
    end
  end

  // Trap context: EPC/cause capture, handler flag, redirect target, lost flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_epc    <= '0;
      r_cause  <= '0;
      r_intrap <= 1'b0;
      r_newpc  <= '0;
      r_retpw  <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_retpw <= w_ret;
      if (w_take) begin
        r_epc    <= PC;
        r_cause  <= w_k;
        r_intrap <= 1'b1;
      end else if (w_ret) begin
        r_intrap <= 1'b0;
      end
      if (w_ret) r_newpc <= r_epc;
      else if ((r_state == S_WAIT) && w_wait_last) r_newpc <= MemRdData;
      if (w_req_any && ((r_state != S_IDLE) || r_intrap)) r_lost <= 1'b1;
    end
  end

  // Output decode; PCWrite is suppressed in a reset cycle
  always_comb begin
    MemRdEn   = 1'b0;
    MemRdAddr = '0;
    Stall     = (r_state != S_IDLE);
    PCWrite   = !Reset && ((r_state == S_REDIRECT) || r_retpw);
    if (r_state == S_READ) begin
      MemRdEn   = 1'b1;
      MemRdAddr = w_vec_addr;
    end
  end

  assign NewPC    = r_newpc;
  assign EPC      = r_epc;
  assign Cause    = r_cause;
  assign InTrap   = r_intrap;
  assign TrapLost = r_lost;

endmodule
